// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and line-level constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write strobe in, serial line and status flags out.
interface uart_tx_fifo_if;

    logic [7:0] data_in;
    logic       in_flag;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output data_in,
        output in_flag,
        input  tx,
        input  tx_busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  data_in,
        input  in_flag,
        output tx,
        output tx_busy,
        output fifo_full,
        output overflow
    );

endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: power-of-two synchronous FIFO with an extra pointer MSB to tell full from empty.
module tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doWrite, doRead;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A pop frees the slot in the same edge, so a write while full is taken if a read accompanies it.
    assign doRead   = rd_i && !empty_o;
    assign doWrite  = wr_i && (!full_o || doRead);
    assign rdData_o = mem_q[rdPtr_q[AW-1:0]];
    assign wrPtr_d  = wrPtr_q + {{AW{1'b0}}, doWrite};
    assign rdPtr_d  = rdPtr_q + {{AW{1'b0}}, doRead};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a registered UART serializer (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_CNT_MAX = 52,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int               CNT_W     = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             pop, startFrame, bitEnd;
    logic             fifoEmpty, fifoFull;
    logic [7:0]       fifoHead;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .wr_i     (bus.in_flag),
        .wrData_i (bus.data_in),
        .rd_i     (pop),
        .rdData_o (fifoHead),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q + 1'b1;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        startFrame = 1'b0;
        bitEnd     = (baudCnt_q == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baudCnt_d  = '0;
                startFrame = !fifoEmpty;
            end
            START: if (bitEnd) begin
                state_d   = DATA;
                baudCnt_d = '0;
                tx_d      = shift_q[0];
            end
            DATA: if (bitEnd) begin
                baudCnt_d = '0;
                if (bitIdx_q == LAST_BIT) begin
                    bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d  = PARITY;
                    tx_d     = parity_q;
`else
                    state_d  = STOP;
                    tx_d     = UART_STOP_BIT;
`endif
                end else begin
                    bitIdx_d = bitIdx_q + 1'b1;
                    shift_d  = {1'b0, shift_q[7:1]};
                    tx_d     = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bitEnd) begin
                state_d   = STOP;
                baudCnt_d = '0;
                tx_d      = UART_STOP_BIT;
            end
`endif
            STOP: if (bitEnd) begin
                baudCnt_d  = '0;
                state_d    = IDLE;
                tx_d       = UART_IDLE_LEVEL;
                startFrame = !fifoEmpty;
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
                tx_d      = UART_IDLE_LEVEL;
            end
        endcase

        // Loading from IDLE and from the end of STOP share one path so back-to-back frames have no gap.
        pop = startFrame;
        if (startFrame) begin
            state_d = START;
            shift_d = fifoHead;
            tx_d    = UART_START_BIT;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifoHead;
`endif
        end
        overflow_d = overflow_q | (bus.in_flag & fifoFull & ~pop);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.tx        = tx_q;
    assign bus.tx_busy   = (state_q != IDLE) || !fifoEmpty;
    assign bus.fifo_full = fifoFull;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench decoding frames off the tx line against hand-picked bytes.
// Define UART_TX_PARITY_EN for the 11-bit frame build.
module tb_uart_tx_fifo;

    localparam int BAUD  = 52;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   checkCount = 0;
    int   errorCount = 0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .BAUD_CNT_MAX (BAUD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Expected line level for bit position b of a frame carrying d.
    function automatic logic expBit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called right after a negedge; in_flag is high for exactly the next rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.data_in = b;
        bus.in_flag = 1'b1;
        @(negedge sys_clk);
        bus.in_flag = 1'b0;
    endtask

    // timeout 0 means the current negedge must already be the first start-bit sample.
    task automatic receiveFrame(input string tag, input logic [7:0] expData, input int timeout,
                                output logic [10:0] seen);
        logic       found;
        int         bad;
        logic [7:0] got;
        found = 1'b0;
        bad   = 0;
        seen  = '1;
        if (timeout == 0) found = (bus.tx == 1'b0);
        for (int n = 0; n < timeout && !found; n++) begin
            @(negedge sys_clk);
            found = (bus.tx == 1'b0);
        end
        checkOutput({tag, "_start"}, 32'(found), 32'd1);
        if (found) begin
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int c = 0; c < BAUD; c++) begin
                    if (b != 0 || c != 0) @(negedge sys_clk);
                    if (bus.tx !== expBit(expData, b)) bad++;
                    if (c == BAUD / 2) seen[b] = bus.tx;
                end
            end
            got = seen[8:1];
            checkOutput({tag, "_data"}, 32'(got), 32'(expData));
            checkOutput({tag, "_shape"}, 32'(bad), 32'd0);
        end
    endtask

    task automatic checkIdleAfter(input string tag);
        checkOutput({tag, "_busy_last"}, 32'(bus.tx_busy), 32'd1);
        @(negedge sys_clk);
        checkOutput({tag, "_busy_end"}, 32'(bus.tx_busy), 32'd0);
        checkOutput({tag, "_tx_idle"}, 32'(bus.tx), 32'd1);
    endtask

    task automatic checkQuiet(input string tag, input int cycles);
        int lows;
        int busy;
        lows = 0;
        busy = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge sys_clk);
            if (bus.tx !== 1'b1) lows++;
            if (bus.tx_busy !== 1'b0) busy++;
        end
        checkOutput({tag, "_tx_low"}, 32'(lows), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [10:0] seen;
        logic        found;
        bus.data_in = '0;
        bus.in_flag = 1'b0;
        sys_rst     = 1'b1;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_tx", 32'(bus.tx), 32'd1);
        checkOutput("rst_busy", 32'(bus.tx_busy), 32'd0);
        checkOutput("rst_full", 32'(bus.fifo_full), 32'd0);
        checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single byte: start must appear exactly two edges after the write edge.
        applyStimulus(8'hA5);
        checkOutput("single_tx_before", 32'(bus.tx), 32'd1);
        checkOutput("single_busy_queued", 32'(bus.tx_busy), 32'd1);
        receiveFrame("single", 8'hA5, 1, seen);
        checkIdleAfter("single");
        repeat (5) @(negedge sys_clk);

        fork
            begin
                applyStimulus(8'h00);
                applyStimulus(8'hFF);
                applyStimulus(8'h3C);
            end
            begin
                receiveFrame("burst0", 8'h00, 4, seen);
                receiveFrame("burst1", 8'hFF, 1, seen);
                receiveFrame("burst2", 8'h3C, 1, seen);
            end
        join
        checkIdleAfter("burst");
        repeat (5) @(negedge sys_clk);

        // 18 writes: first pops at once, 16 fill the FIFO, the last is dropped.
        fork
            begin
                for (int i = 0; i < 17; i++) applyStimulus(8'(8'h40 + i));
                checkOutput("ovf_full_before", 32'(bus.fifo_full), 32'd1);
                checkOutput("ovf_flag_before", 32'(bus.overflow), 32'd0);
                applyStimulus(8'hEE);
                checkOutput("ovf_full_after", 32'(bus.fifo_full), 32'd1);
                checkOutput("ovf_flag_set", 32'(bus.overflow), 32'd1);
            end
            begin
                for (int i = 0; i < 17; i++)
                    receiveFrame($sformatf("ovf%0d", i), 8'(8'h40 + i), (i == 0) ? 4 : 1, seen);
            end
        join
        checkIdleAfter("ovf");
        checkQuiet("ovf_no_extra", 200);
        checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset during data bit 3 of 0x55 (a low bit) must force the line high at once.
        applyStimulus(8'h55);
        found = 1'b0;
        for (int n = 0; n < 4 && !found; n++) begin
            @(negedge sys_clk);
            found = (bus.tx == 1'b0);
        end
        checkOutput("rstmid_start", 32'(found), 32'd1);
        repeat (4 * BAUD + 10) @(negedge sys_clk);
        checkOutput("rstmid_bit3", 32'(bus.tx), 32'd0);
        sys_rst = 1'b1;
        #1;
        checkOutput("rstmid_tx", 32'(bus.tx), 32'd1);
        checkOutput("rstmid_busy", 32'(bus.tx_busy), 32'd0);
        checkOutput("rstmid_ovf", 32'(bus.overflow), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        checkQuiet("rstmid_quiet", 300);
        applyStimulus(8'h81);
        receiveFrame("rstmid_next", 8'h81, 1, seen);
        checkIdleAfter("rstmid");
        repeat (5) @(negedge sys_clk);

        // Fill the FIFO, then write on the very edge the first frame ends and pops.
        fork
            begin
                for (int i = 0; i < 17; i++) applyStimulus(8'(8'h60 + i));
            end
            receiveFrame("ffp0", 8'h60, 4, seen);
        join
        checkOutput("ffp_full_pre", 32'(bus.fifo_full), 32'd1);
        bus.data_in = 8'hD2;
        bus.in_flag = 1'b1;
        @(negedge sys_clk);
        bus.in_flag = 1'b0;
        checkOutput("ffp_full_kept", 32'(bus.fifo_full), 32'd1);
        checkOutput("ffp_ovf_clear", 32'(bus.overflow), 32'd0);
        receiveFrame("ffp1", 8'h61, 0, seen);
        for (int i = 2; i < 17; i++)
            receiveFrame($sformatf("ffp%0d", i), 8'(8'h60 + i), 1, seen);
        receiveFrame("ffp_tail", 8'hD2, 1, seen);
        checkIdleAfter("ffp");

`ifdef UART_TX_PARITY_EN
        repeat (5) @(negedge sys_clk);
        applyStimulus(8'h07);
        receiveFrame("par07", 8'h07, 1, seen);
        checkOutput("par07_bit", 32'(seen[9]), 32'd1);
        checkIdleAfter("par07");
        repeat (5) @(negedge sys_clk);
        applyStimulus(8'h03);
        receiveFrame("par03", 8'h03, 1, seen);
        checkOutput("par03_bit", 32'(seen[9]), 32'd0);
        checkIdleAfter("par03");
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_CNT_MAX, default 52; clock cycles per UART bit.
REQ-002 Parameter FIFO_DEPTH, default 16; byte entries buffered, power of two, at least 2.
REQ-003 sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset; asynchronous, active-high.
REQ-005 data_in  input  8  byte to transmit, such as a processed pixel from the edge-detection pipeline.
REQ-006 in_flag  input  1  one-cycle write strobe; data_in is valid while it is high.
REQ-007 tx  output  1  UART serial line; idles high.
REQ-008 tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-010 overflow  output  1  sticky flag; set when a byte is dropped.

Function
REQ-011 Frame format: start bit 0, then data bits LSB first, then stop bit 1; each bit holds exactly BAUD_CNT_MAX cycles.
REQ-012 FSM states: IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
- IDLE->START when the FIFO is non-empty.
- START->DATA when the bit counter reaches BAUD_CNT_MAX-1.
- DATA->STOP after bit 7 ends.
- STOP->START if the FIFO is non-empty at the end of the stop bit; otherwise STOP->IDLE.
REQ-013 On the IDLE->START edge: pop the FIFO head into the shift register and register tx to 0.
- Latency: tx falls 2 edges after the in_flag edge that writes into an empty FIFO.
REQ-014 Back-to-back frames: no idle cycles between the end of a stop bit and the next start bit.
REQ-015 The baud counter is 0..BAUD_CNT_MAX-1.
- Width is the clog2 of BAUD_CNT_MAX.
- Clears on every bit boundary and in IDLE.
REQ-016 The bit index is 3 bits and wraps only by leaving DATA.
REQ-017 tx is driven from a flop; no combinational path from inputs to tx.
REQ-018 Write while full with no pop in the same cycle: discard the byte, FIFO unchanged, set overflow.
REQ-019 Write while full with a pop in the same cycle: accept the write; occupancy stays FIFO_DEPTH.
REQ-020 Write while empty and IDLE: the byte is stored, then popped on the next edge (REQ-013); no bypass.
REQ-021 FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap is natural; full/empty are decided by comparing the MSBs.

Reset
REQ-022 While sys_rst is high:
- state=IDLE, tx=1, tx_busy=0, fifo_full=0, overflow=0.
- FIFO pointers and counters are 0.
- Outputs follow asynchronously.
REQ-023 Reset mid-frame aborts the frame immediately; buffered bytes are lost; the first frame after release is a fresh start bit.
- overflow clears only on reset.

Configuration
REQ-024 Macro UART_TX_PARITY_EN:
- Defined: insert a PARITY state between DATA and STOP; it transmits even parity (XOR of the 8 data bits); the frame is 11 bits.
- Undefined: no PARITY state and no parity logic; the frame is 10 bits.

Structure
REQ-025 Shared package uart_pkg holds:
- the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
- constants UART_IDLE_LEVEL=1, UART_START_BIT=0, UART_STOP_BIT=1, UART_DATA_BITS=8.
REQ-026 The FIFO is a sub-module, tx_fifo: synchronous write/read, full/empty flags, same clock and reset.
- The FSM and serializer stay in uart_tx_fifo.

Verification
REQ-027 Single byte, BAUD_CNT_MAX=52:
- Stimulus: write 0xA5.
- Response: tx = 0,1,0,1,0,0,1,0,1,1, each for 52 cycles, 520 cycles total; tx_busy falls the cycle after the stop bit ends.
REQ-028 Burst:
- Stimulus: write 0x00, 0xFF, 0x3C on consecutive cycles.
- Response: three frames with zero gap, 1560 cycles total; the data bits of frame 2 are all 1.
REQ-029 Overflow, FIFO_DEPTH=16:
- Stimulus: write 18 bytes on consecutive cycles from empty.
- Response: the first is popped, the next 16 fill the FIFO, the 18th is dropped; overflow=1; exactly 17 frames go out.
REQ-030 Reset mid-frame:
- Stimulus: assert sys_rst during data bit 3 of 0x55, for 3 cycles.
- Response: tx=1 the same cycle; no further frames; a following write of 0x81 produces a clean frame.
REQ-031 Parity build with UART_TX_PARITY_EN:
- Stimulus: write 0x07.
- Response: parity bit 1; frame is 11 bits, 572 cycles.
- Stimulus: write 0x03.
- Response: parity bit 0.
REQ-032 Full-and-pop:
- Stimulus: with the FIFO full, write on the cycle a frame ends and pops.
- Response: the byte is accepted, fifo_full stays 1, overflow stays 0.
